// File: rtl/and4_stim_sequencer_if.sv
// Signal bundle between the AND-tree stimulus sequencer and the tree/test harness.
// The master side drives the pattern and sweep status; the slave side supplies start and the tree output.
interface and4_stim_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             dut_out;
   logic [WIDTH-1:0] stim;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH:0]   err_count;
   logic [WIDTH-1:0] first_fail;
   logic             first_fail_valid;

   modport master (
      input  start,
      input  dut_out,
      output stim,
      output busy,
      output done,
      output pass,
      output err_count,
      output first_fail,
      output first_fail_valid
   );

   modport slave (
      output start,
      output dut_out,
      input  stim,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  first_fail,
      input  first_fail_valid
   );
endinterface

// File: rtl/and4_stim_sequencer.sv
// Exhaustive stimulus sweep for an AND-reduction tree: drives every pattern, samples the tree after
// HOLD cycles, and reports error count, first failing pattern and pass/done status.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | after reset, waiting for start; all outputs at reset value
//   S_DRIVE | pattern r_idx on stim, hold counter running, sample at HOLD-1
//   S_DONE  | sweep complete, results held, start re-arms a new sweep
module and4_stim_sequencer #(
   parameter int WIDTH = 4,
   parameter int HOLD  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   and4_stim_sequencer_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] IDX_LAST  = '1;
   localparam logic [WIDTH-1:0] IDX_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   ERR_ONE   = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_idx;
   logic [7:0]       r_hold_cnt;
   logic [WIDTH:0]   r_err_count;
   logic [WIDTH-1:0] r_first_fail;
   logic             r_first_fail_valid;

   logic             w_launch;
   logic             w_sample;
   logic             w_last;
   logic             w_expected;
   logic             w_mismatch;

   // start is only honoured outside a sweep; in S_DRIVE it is ignored entirely
   assign w_launch   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_sample   = (r_state == S_DRIVE) && (r_hold_cnt == HOLD_LAST);
   assign w_last     = (r_idx == IDX_LAST);
   assign w_expected = &r_idx;
   assign w_mismatch = w_sample && (bus.dut_out != w_expected);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (w_sample && w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               w_state_nxt = S_DRIVE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx              <= '0;
         r_hold_cnt         <= '0;
         r_err_count        <= '0;
         r_first_fail       <= '0;
         r_first_fail_valid <= 1'b0;
      end else if (w_launch) begin
         r_idx              <= '0;
         r_hold_cnt         <= '0;
         r_err_count        <= '0;
         r_first_fail       <= '0;
         r_first_fail_valid <= 1'b0;
      end else if (r_state == S_DRIVE) begin
         if (w_sample) begin
            r_hold_cnt <= '0;
            if (!w_last) begin
               r_idx <= r_idx + IDX_ONE;
            end
            if (w_mismatch) begin
               r_err_count <= r_err_count + ERR_ONE;
               if (!r_first_fail_valid) begin
                  r_first_fail       <= r_idx;
                  r_first_fail_valid <= 1'b1;
               end
            end
         end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
         end
      end
   end

   // stim follows r_idx directly, so S_DONE keeps showing the final all-ones pattern
   always_comb begin
      bus.stim             = r_idx;
      bus.busy             = (r_state == S_DRIVE);
      bus.done             = (r_state == S_DONE);
      bus.pass             = (r_state == S_DONE) && (r_err_count == '0);
      bus.err_count        = r_err_count;
      bus.first_fail       = r_first_fail;
      bus.first_fail_valid = r_first_fail_valid;
   end

endmodule
